// File: rtl/pipelined_ripple_adder.sv
// rtl/pipelined_ripple_adder.sv - pipelined segmented ripple add/subtract with valid/ready handshake
module pipelined_ripple_adder #(
  parameter int WIDTH = 16,
  parameter int SEG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STAGES = WIDTH / SEG_W;

  generate
    if (WIDTH < 1 || SEG_W < 1 || SEG_W > WIDTH || (WIDTH % SEG_W) != 0) begin : g_bad_cfg
      $error("pipelined_ripple_adder: SEG_W must be >= 1 and divide WIDTH");
    end
  endgenerate

  // Stage registers: each stage carries the whole beat (operands, partial sum, carry, valid).
  // Stage k owns sum segment k; lower segments ride along already resolved, upper operand
  // segments ride along waiting for their stage.
  logic             st_v [STAGES];
  logic [WIDTH-1:0] st_a [STAGES];
  logic [WIDTH-1:0] st_b [STAGES];
  logic [WIDTH-1:0] st_s [STAGES];
  logic             st_c [STAGES];
  logic             ovf_q;

  // Inputs seen by each stage's adder: stage 0 from the ports, stage k from stage k-1.
  logic             src_v [STAGES];
  logic [WIDTH-1:0] src_a [STAGES];
  logic [WIDTH-1:0] src_b [STAGES];
  logic [WIDTH-1:0] src_s [STAGES];
  logic             src_c [STAGES];
  logic [SEG_W:0]   seg_res [STAGES];
  logic [WIDTH-1:0] nxt_s [STAGES];
  logic             ovf_nxt;
  logic             adv;

  // The whole pipeline moves together; it only freezes when the output holds an unaccepted beat.
  assign adv       = !st_v[STAGES-1] || out_ready;
  assign in_ready  = adv;
  assign out_valid = st_v[STAGES-1];
  assign sum       = st_s[STAGES-1];
  assign cout      = st_c[STAGES-1];
  assign ovf       = ovf_q;

  // Per-stage segment adders; the only carry path into a stage comes from a register.
  always_comb begin
    src_v[0] = in_valid;
    src_a[0] = a;
    src_b[0] = sub ? ~b : b;
    src_c[0] = sub ? ~cin : cin;
    src_s[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      src_v[k] = st_v[k-1];
      src_a[k] = st_a[k-1];
      src_b[k] = st_b[k-1];
      src_s[k] = st_s[k-1];
      src_c[k] = st_c[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      seg_res[k] = {1'b0, src_a[k][k*SEG_W +: SEG_W]}
                 + {1'b0, src_b[k][k*SEG_W +: SEG_W]}
                 + {{SEG_W{1'b0}}, src_c[k]};
      nxt_s[k] = src_s[k];
      nxt_s[k][k*SEG_W +: SEG_W] = seg_res[k][SEG_W-1:0];
    end
    // Carry into the MSB is recovered as sum ^ a ^ b at that bit.
    ovf_nxt = seg_res[STAGES-1][SEG_W]
            ^ nxt_s[STAGES-1][WIDTH-1]
            ^ src_a[STAGES-1][WIDTH-1]
            ^ src_b[STAGES-1][WIDTH-1];
  end

  // Pipeline register bank: reset empties every stage, otherwise shift when allowed to advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        st_v[k] <= 1'b0;
        st_a[k] <= '0;
        st_b[k] <= '0;
        st_s[k] <= '0;
        st_c[k] <= 1'b0;
      end
      ovf_q <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        st_v[k] <= src_v[k];
        st_a[k] <= src_a[k];
        st_b[k] <= src_b[k];
        st_s[k] <= nxt_s[k];
        st_c[k] <= seg_res[k][SEG_W];
      end
      ovf_q <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// tb/tb_pipelined_ripple_adder.sv - self-checking bench for pipelined_ripple_adder
module tb_pipelined_ripple_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] a_drv;
  logic [15:0] b_drv;
  logic        cin_drv;
  logic        sub_drv;

  int checks = 0;
  int errors = 0;
  int base0, base1, base2;
  bit rand_done;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Three configurations share the stimulus; each keeps its own scoreboard.
  generate
    for (genvar g = 0; g < 3; g++) begin : g_cfg
      localparam int W = (g == 2) ? 8 : 16;
      localparam int S = (g == 0) ? 4 : ((g == 1) ? 16 : 1);

      logic           d_in_ready;
      logic           d_out_valid;
      logic           d_cout;
      logic           d_ovf;
      logic [W-1:0]   d_sum;
      logic [W+1:0]   q[$];
      logic [W+1:0]   exp_v;
      int             n_acc = 0;
      logic           held = 1'b0;
      logic [W+1:0]   held_val;

      pipelined_ripple_adder #(.WIDTH(W), .SEG_W(S)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (d_in_ready),
        .a         (a_drv[W-1:0]),
        .b         (b_drv[W-1:0]),
        .cin       (cin_drv),
        .sub       (sub_drv),
        .out_valid (d_out_valid),
        .out_ready (out_ready),
        .sum       (d_sum),
        .cout      (d_cout),
        .ovf       (d_ovf)
      );

      // Reference: plain integer arithmetic, signed overflow from operand/result signs.
      function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic c, input logic s);
        logic [W-1:0] y_eff;
        logic         c_eff;
        logic [W:0]   full;
        logic         v;
        y_eff = s ? ~y : y;
        c_eff = s ? ~c : c;
        full  = {1'b0, x} + {1'b0, y_eff} + {{W{1'b0}}, c_eff};
        v     = (x[W-1] == y_eff[W-1]) && (full[W-1] != x[W-1]);
        return {v, full[W], full[W-1:0]};
      endfunction

      always @(negedge clk) begin
        if (rst) begin
          q.delete();
          held = 1'b0;
        end else begin
          if (held)
            check($sformatf("stall_hold_cfg%0d", g), 32'({d_ovf, d_cout, d_sum}), 32'(held_val));
          check($sformatf("phantom_out_cfg%0d", g), 32'(d_out_valid && q.size() == 0), 32'd0);
          if (d_out_valid && out_ready && q.size() > 0) begin
            exp_v = q.pop_front();
            check($sformatf("result_cfg%0d", g), 32'({d_ovf, d_cout, d_sum}), 32'(exp_v));
          end
          if (in_valid && d_in_ready) begin
            q.push_back(model(a_drv[W-1:0], b_drv[W-1:0], cin_drv, sub_drv));
            n_acc++;
          end
          held     = d_out_valid && !out_ready;
          held_val = {d_ovf, d_cout, d_sum};
        end
      end
    end
  endgenerate

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic run_one(input logic [15:0] x, input logic [15:0] y, input logic c, input logic s,
                         input logic [15:0] e_sum, input logic e_c, input logic e_o, input string tag);
    int lat;
    a_drv = x; b_drv = y; cin_drv = c; sub_drv = s; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 1;
    while (!g_cfg[0].d_out_valid && lat < 20) begin
      step();
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'd4);
    check({tag, "_sum"}, 32'(g_cfg[0].d_sum), 32'(e_sum));
    check({tag, "_cout"}, 32'(g_cfg[0].d_cout), 32'(e_c));
    check({tag, "_ovf"}, 32'(g_cfg[0].d_ovf), 32'(e_o));
    step();
    check({tag, "_one_cycle"}, 32'(g_cfg[0].d_out_valid), 32'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a_drv = '0; b_drv = '0; cin_drv = 1'b0; sub_drv = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("reset_out_valid", 32'(g_cfg[0].d_out_valid), 32'd0);
    check("reset_sum", 32'(g_cfg[0].d_sum), 32'd0);
    check("reset_cout_ovf", 32'({g_cfg[0].d_cout, g_cfg[0].d_ovf}), 32'd0);
    check("reset_in_ready", 32'(g_cfg[0].d_in_ready), 32'd1);

    run_one(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "wrap");
    run_one(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, "pos_ovf");
    run_one(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, "neg_ovf");
    run_one(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub_borrow");
    run_one(16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0, "sub_cin");

    // Back-to-back beats with a two-cycle downstream stall on the first result.
    sub_drv = 1'b0; cin_drv = 1'b0; in_valid = 1'b1;
    a_drv = 16'd1; b_drv = 16'd1; step();
    a_drv = 16'd2; b_drv = 16'd2; step();
    a_drv = 16'd3; b_drv = 16'd3; step();
    in_valid = 1'b0; step();
    out_ready = 1'b0; in_valid = 1'b1; a_drv = 16'h1234; b_drv = 16'h4321;
    #1;
    check("stall_c4_valid", 32'(g_cfg[0].d_out_valid), 32'd1);
    check("stall_c4_sum", 32'(g_cfg[0].d_sum), 32'h0002);
    check("stall_c4_in_ready", 32'(g_cfg[0].d_in_ready), 32'd0);
    step();
    check("stall_c5_sum", 32'(g_cfg[0].d_sum), 32'h0002);
    check("stall_c5_in_ready", 32'(g_cfg[0].d_in_ready), 32'd0);
    step();
    out_ready = 1'b1; in_valid = 1'b0;
    #1;
    check("stall_release_sum", 32'(g_cfg[0].d_sum), 32'h0002);
    check("stall_release_in_ready", 32'(g_cfg[0].d_in_ready), 32'd1);
    step();
    check("order_second", 32'({g_cfg[0].d_out_valid, g_cfg[0].d_sum}), 32'h1_0004);
    step();
    check("order_third", 32'({g_cfg[0].d_out_valid, g_cfg[0].d_sum}), 32'h1_0006);
    step();
    check("order_drained", 32'(g_cfg[0].d_out_valid), 32'd0);

    // Reset with two beats in flight: nothing may surface afterwards.
    in_valid = 1'b1; a_drv = 16'h0010; b_drv = 16'h0020; step();
    a_drv = 16'h0030; b_drv = 16'h0040; step();
    in_valid = 1'b0; rst = 1'b1; step();
    rst = 1'b0;
    check("flush_out_valid", 32'(g_cfg[0].d_out_valid), 32'd0);
    check("flush_sum", 32'(g_cfg[0].d_sum), 32'd0);
    for (int i = 0; i < 10; i++) begin
      step();
      check("flush_no_stale", 32'(g_cfg[0].d_out_valid), 32'd0);
    end

    // Random traffic on all three configurations.
    base0 = g_cfg[0].n_acc; base1 = g_cfg[1].n_acc; base2 = g_cfg[2].n_acc;
    rand_done = 1'b0;
    for (int cyc = 0; cyc < 20000 && !rand_done; cyc++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      a_drv     = 16'($urandom);
      b_drv     = 16'($urandom);
      cin_drv   = 1'($urandom);
      sub_drv   = 1'($urandom);
      step();
      rand_done = (g_cfg[0].n_acc - base0 >= 1000) && (g_cfg[1].n_acc - base1 >= 1000)
               && (g_cfg[2].n_acc - base2 >= 1000);
    end
    check("random_budget", 32'(rand_done), 32'd1);

    in_valid = 1'b0; out_ready = 1'b1;
    repeat (20) step();
    check("drain_cfg0", 32'(g_cfg[0].q.size()), 32'd0);
    check("drain_cfg1", 32'(g_cfg[1].q.size()), 32'd0);
    check("drain_cfg2", 32'(g_cfg[2].q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
